// File: rtl/mseq_pkg.sv
// Shared definitions for the micro-sequencer: widths, condition codes, FSM states
// and the opcode dispatch table.
package mseq_pkg;

    localparam int UPC_W     = 16;
    localparam int JMP_W     = 7;
    localparam int OPC_W     = 8;
    localparam int ROM_DEPTH = 86;

    localparam logic [UPC_W-1:0] FETCH_ADDR = 16'd1;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_NZ     = 2'b10,
        COND_RSV    = 2'b11
    } cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [UPC_W-1:0] addr;
    } disp_t;

    // Opcodes missing from this table are illegal dispatch targets.
    function automatic disp_t dispatch_addr(input logic [OPC_W-1:0] opc);
        disp_t d;
        d.valid = 1'b1;
        d.addr  = '0;
        case (opc)
            8'h01:   d.addr = 16'd4;
            8'h02:   d.addr = 16'd8;
            8'h03:   d.addr = 16'd12;
            8'h04:   d.addr = 16'd16;
            8'h0F:   d.addr = 16'd60;
            8'h14:   d.addr = 16'd80;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mseq_dispatch.sv
// Combinational opcode-to-micro-address lookup used when the ROM word sets BT.
module mseq_dispatch
    import mseq_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             valid,
    output logic [UPC_W-1:0] addr
);

    disp_t d;

    always_comb begin
        d     = dispatch_addr(opcode);
        valid = d.valid;
        addr  = d.addr;
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram counter with next-address selection and IDLE/RUN/HALT control.
// Optional trap behaviour for reserved conditions and illegal targets: MSEQ_TRAP_EN.
module micro_sequencer
    import mseq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [OPC_W-1:0] opcode,
    input  logic             z_flag,
    input  logic             bt,
    input  logic [1:0]       condition,
    input  logic [JMP_W-1:0] jump_addr,
    output logic [UPC_W-1:0] upc,
    output logic             running,
    output logic             halted,
    output logic             err
);

`ifdef MSEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [UPC_W:0] ROM_LIMIT = (UPC_W+1)'(ROM_DEPTH);

    state_t           state_q, state_d;
    logic [UPC_W-1:0] upc_q, upc_d;
    logic             err_q, err_d;

    logic             disp_valid;
    logic [UPC_W-1:0] disp_addr;
    logic [UPC_W:0]   jump_ext;
    logic [UPC_W:0]   seq_ext;
    logic [UPC_W:0]   tgt;
    logic             tgt_bad;
    logic             self_loop;
    logic             rsv_hit;

    mseq_dispatch u_dispatch (
        .opcode (opcode),
        .valid  (disp_valid),
        .addr   (disp_addr)
    );

    // Targets are kept one bit wider so upc+1 past the top of the ROM is caught.
    always_comb begin
        jump_ext  = {{(UPC_W+1-JMP_W){1'b0}}, jump_addr};
        seq_ext   = {1'b0, upc_q} + (UPC_W+1)'(1);
        tgt       = seq_ext;
        tgt_bad   = 1'b0;
        self_loop = 1'b0;
        rsv_hit   = 1'b0;
        if (bt) begin
            tgt     = {1'b0, disp_addr};
            tgt_bad = !disp_valid;
        end else begin
            case (cond_t'(condition))
                COND_ALWAYS: begin
                    tgt       = jump_ext;
                    self_loop = (jump_ext == {1'b0, upc_q});
                end
                COND_Z:   tgt = z_flag ? jump_ext : seq_ext;
                COND_NZ:  tgt = z_flag ? seq_ext : jump_ext;
                COND_RSV: begin
                    tgt     = jump_ext;
                    rsv_hit = TRAP_EN;
                end
                default:  tgt = seq_ext;
            endcase
        end
        if (tgt >= ROM_LIMIT) begin
            tgt_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            upc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
        end
    end

    // A stalled cycle never advances, so a self-loop halt waits for stall to drop.
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        err_d   = err_q;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    upc_d   = FETCH_ADDR;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (self_loop) begin
                        state_d = HALT;
                    end else if (TRAP_EN && (rsv_hit || tgt_bad)) begin
                        state_d = HALT;
                        upc_d   = '0;
                        err_d   = 1'b1;
                    end else if (tgt_bad) begin
                        upc_d = FETCH_ADDR;
                    end else begin
                        upc_d = tgt[UPC_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upc     = upc_q;
        running = (state_q == RUN);
        halted  = (state_q == HALT);
        err     = TRAP_EN ? err_q : 1'b0;
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and random stimulus for micro_sequencer against a behavioural model of
// the sequencing rules; the bench acts as the combinational microcode ROM.
module tb_micro_sequencer;

`ifdef MSEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [7:0]  opcode;
    logic        z_flag;
    logic        bt;
    logic [1:0]  condition;
    logic [6:0]  jump_addr;
    logic [15:0] upc;
    logic        running;
    logic        halted;
    logic        err;

    micro_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .opcode    (opcode),
        .z_flag    (z_flag),
        .bt        (bt),
        .condition (condition),
        .jump_addr (jump_addr),
        .upc       (upc),
        .running   (running),
        .halted    (halted),
        .err       (err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int          disp_tbl[int];
    int          m_upc;
    bit          m_running;
    bit          m_halted;
    bit          m_err;
    logic [15:0] exp_q[$];

    int vectors;
    int miscompares;

    // Applies the rules to the inputs about to be clocked in.
    task automatic model_edge();
        int t;
        bit bad;
        bit halt_now;
        t = m_upc;
        bad = 1'b0;
        halt_now = 1'b0;
        if (!rst_n) begin
            m_upc = 0; m_running = 0; m_halted = 0; m_err = 0;
        end else if (!m_running) begin
            if (start) begin
                m_upc = 1; m_running = 1; m_halted = 0; m_err = 0;
            end
        end else if (!stall) begin
            if (bt) begin
                if (disp_tbl.exists(int'(opcode))) t = disp_tbl[int'(opcode)];
                else bad = 1'b1;
            end else if (condition == 2'd0 && int'(jump_addr) == m_upc) begin
                halt_now = 1'b1;
            end else begin
                case (condition)
                    2'd0: t = int'(jump_addr);
                    2'd1: t = z_flag ? int'(jump_addr) : m_upc + 1;
                    2'd2: t = z_flag ? m_upc + 1 : int'(jump_addr);
                    default: begin
                        t = int'(jump_addr);
                        if (TRAP) bad = 1'b1;
                    end
                endcase
            end
            if (halt_now) begin
                m_running = 0; m_halted = 1;
            end else begin
                if (t >= 86) bad = 1'b1;
                if (bad && TRAP) begin
                    m_upc = 0; m_err = 1; m_running = 0; m_halted = 1;
                end else if (bad) begin
                    m_upc = 1;
                end else begin
                    m_upc = t;
                end
            end
        end
        exp_q.push_back(16'(m_upc));
    endtask

    // Scoreboard check of all outputs
    task automatic check(input string tag);
        logic [15:0] exp_upc;
        exp_upc = exp_q.pop_front();
        vectors++;
        assert (upc === exp_upc) else begin
            miscompares++;
            $error("FAIL %s upc: observed %0d expected %0d", tag, upc, exp_upc);
        end
        vectors++;
        assert (running === m_running) else begin
            miscompares++;
            $error("FAIL %s running: observed %b expected %b", tag, running, m_running);
        end
        vectors++;
        assert (halted === m_halted) else begin
            miscompares++;
            $error("FAIL %s halted: observed %b expected %b", tag, halted, m_halted);
        end
        vectors++;
        assert (err === m_err) else begin
            miscompares++;
            $error("FAIL %s err: observed %b expected %b", tag, err, m_err);
        end
    endtask

    // Driver tasks
    task automatic step(input logic r, input logic s, input logic st, input logic b,
                        input logic [1:0] c, input logic [6:0] j, input logic z,
                        input logic [7:0] op, input string tag);
        rst_n = r; start = s; stall = st; bt = b;
        condition = c; jump_addr = j; z_flag = z; opcode = op;
        model_edge();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic word(input logic [1:0] c, input logic [6:0] j, input logic z, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, c, j, z, 8'h00, tag);
    endtask

    task automatic disp(input logic [7:0] op, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 7'd0, 1'b0, op, tag);
    endtask

    task automatic go(input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd0, 1'b0, 8'h00, tag);
    endtask

    initial begin
        int keys[6];
        vectors = 0;
        miscompares = 0;
        disp_tbl[8'h01] = 4;  disp_tbl[8'h02] = 8;  disp_tbl[8'h03] = 12;
        disp_tbl[8'h04] = 16; disp_tbl[8'h0F] = 60; disp_tbl[8'h14] = 80;
        keys = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h14};
        m_upc = 0; m_running = 0; m_halted = 0; m_err = 0;

        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7'd0, 1'b0, 8'h00, "reset");
        word(2'd0, 7'd5, 1'b0, "idle_no_start");
        go("start");
        word(2'd0, 7'd2, 1'b0, "jump_2");
        word(2'd0, 7'd3, 1'b0, "jump_3");
        disp(8'h0F, "dispatch_0f");
        word(2'd1, 7'd62, 1'b1, "cond_z_taken");
        word(2'd0, 7'd60, 1'b0, "back_60");
        word(2'd1, 7'd62, 1'b0, "cond_z_not_taken");
        disp(8'h14, "dispatch_14");
        word(2'd0, 7'd80, 1'b0, "self_loop_halt");
        for (int i = 0; i < 10; i++) word(2'd0, 7'd80, 1'b0, "halt_hold");
        go("restart_from_halt");

        word(2'd0, 7'd5, 1'b0, "jump_5");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'd6, 1'b0, 8'h00, "stall_hold");
        word(2'd0, 7'd6, 1'b0, "stall_release");
        word(2'd2, 7'd20, 1'b1, "cond_nz_not_taken");
        word(2'd2, 7'd28, 1'b0, "cond_nz_taken");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 7'd40, 1'b0, 8'h00, "start_ignored_in_run");
        word(2'd0, 7'd28, 1'b0, "jump_28");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 7'd9, 1'b0, 8'h00, "reset_mid_run");
        word(2'd0, 7'd9, 1'b0, "idle_after_reset");

        go("start_again");
        disp(8'h55, "dispatch_illegal");
        go("restart_after_illegal");
        word(2'd0, 7'd100, 1'b0, "jump_out_of_range");
        go("restart_after_range");
        word(2'd0, 7'd85, 1'b0, "jump_85");
        word(2'd1, 7'd0, 1'b0, "seq_past_end");
        go("restart_after_seq");
        word(2'd3, 7'd7, 1'b0, "cond_reserved");
        go("restart_after_rsv");
        word(2'd0, 7'd7, 1'b0, "jump_7");
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'd7, 1'b0, 8'h00, "halt_under_stall");
        word(2'd0, 7'd7, 1'b0, "halt_after_stall");
        go("restart_final");

        for (int n = 0; n < 400; n++) begin
            logic r, s, st, b, z;
            logic [1:0] c;
            logic [6:0] j;
            logic [7:0] op;
            r  = ($urandom_range(0, 59) != 0);
            s  = m_running ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 5) == 0);
            c  = 2'($urandom_range(0, 3));
            z  = 1'($urandom_range(0, 1));
            j  = ($urandom_range(0, 5) == 0) ? 7'(m_upc) : 7'($urandom_range(0, 100));
            op = ($urandom_range(0, 9) < 7) ? 8'(keys[$urandom_range(0, 5)]) : 8'($urandom_range(0, 255));
            step(r, s, st, b, c, j, z, op, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
